// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel-tick divider, h/v counters, four pattern modes.
// Optional edge border (all-ones frame around the active area) enabled by defining VGA_PATTERN_BORDER_EN.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CLK_DIV    = 2,
    parameter int COLOR_W    = 1,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32
) (
    input  logic                   CLK_50MHZ,
    input  logic                   reset,
    input  logic [2:0]             sw,
    input  logic [1:0]             mode,
    output logic                   hsync,
    output logic                   vsync,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   video_on,
    output logic [9:0]             pixel_x,
    output logic [9:0]             pixel_y,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = 3 * COLOR_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] BAR_LAST  = 10'(H_ACTIVE / 8 - 1);
    localparam logic [9:0] BOX       = 10'(BOX_SIZE);
    localparam logic [9:0] BX_MAX    = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] BY_MAX    = 10'(V_ACTIVE - BOX_SIZE);

    logic [DIV_W-1:0] div_reg;
    logic [9:0]       h_reg, v_reg;
    logic [9:0]       bar_cnt_reg;
    logic [2:0]       bar_idx_reg;
    logic [9:0]       bx_reg, by_reg;
    logic             dx_reg, dy_reg;
    logic [1:0]       mode_reg;
    logic [2:0]       sw_reg;

    logic             hsync_reg, vsync_reg, video_on_reg, frame_start_reg;
    logic [CW-1:0]    rgb_reg;
    logic [9:0]       pixel_x_reg, pixel_y_reg;

    logic             tick, h_wrap, v_wrap, origin, active, in_box;
    logic [1:0]       mode_eff;
    logic [2:0]       sw_eff;
    logic [CW-1:0]    sw_rgb, bar_rgb, pat;

    assign tick   = (div_reg == DIV_LAST);
    assign h_wrap = (h_reg == H_LAST);
    assign v_wrap = (v_reg == V_LAST);
    assign origin = (h_reg == 10'd0) && (v_reg == 10'd0);
    assign active = (h_reg < H_ACT) && (v_reg < V_ACT);

    // The latch happens on the (0,0) tick, so that pixel already uses the new selection.
    assign mode_eff = origin ? mode : mode_reg;
    assign sw_eff   = origin ? sw   : sw_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign sw_rgb[gi*COLOR_W +: COLOR_W]  = {COLOR_W{sw_eff[gi]}};
            assign bar_rgb[gi*COLOR_W +: COLOR_W] = {COLOR_W{bar_idx_reg[gi]}};
        end
    endgenerate

    assign in_box = (h_reg >= bx_reg) && (h_reg < bx_reg + BOX) &&
                    (v_reg >= by_reg) && (v_reg < by_reg + BOX);

    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) begin
                h_reg <= h_wrap ? 10'd0 : h_reg + 10'd1;
                if (h_wrap)
                    v_reg <= v_wrap ? 10'd0 : v_reg + 10'd1;
            end
        end
    end

    // Bar index tracks h with a per-line counter instead of dividing h by the bar width.
    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            bar_cnt_reg <= '0;
            bar_idx_reg <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                bar_cnt_reg <= '0;
                bar_idx_reg <= '0;
            end else if (bar_cnt_reg == BAR_LAST) begin
                bar_cnt_reg <= '0;
                bar_idx_reg <= bar_idx_reg + 3'd1;
            end else begin
                bar_cnt_reg <= bar_cnt_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            mode_reg <= '0;
            sw_reg   <= '0;
        end else if (tick && origin) begin
            mode_reg <= mode;
            sw_reg   <= sw;
        end
    end

    // Box steps once per frame; at an edge it reverses and steps back in the same frame.
    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            bx_reg <= '0;
            by_reg <= '0;
            dx_reg <= 1'b1;
            dy_reg <= 1'b1;
        end else if (tick && h_wrap && v_wrap) begin
            if (dx_reg) begin
                if (bx_reg == BX_MAX) begin
                    dx_reg <= 1'b0;
                    bx_reg <= bx_reg - 10'd1;
                end else begin
                    bx_reg <= bx_reg + 10'd1;
                end
            end else if (bx_reg == 10'd0) begin
                dx_reg <= 1'b1;
                bx_reg <= bx_reg + 10'd1;
            end else begin
                bx_reg <= bx_reg - 10'd1;
            end

            if (dy_reg) begin
                if (by_reg == BY_MAX) begin
                    dy_reg <= 1'b0;
                    by_reg <= by_reg - 10'd1;
                end else begin
                    by_reg <= by_reg + 10'd1;
                end
            end else if (by_reg == 10'd0) begin
                dy_reg <= 1'b1;
                by_reg <= by_reg + 10'd1;
            end else begin
                by_reg <= by_reg - 10'd1;
            end
        end
    end

    always_comb begin
        pat = '0;
        case (mode_eff)
            2'd0:    pat = sw_rgb;
            2'd1:    pat = bar_rgb;
            2'd2:    if (h_reg[CHECK_LOG2] ^ v_reg[CHECK_LOG2]) pat = sw_rgb;
            2'd3:    if (in_box) pat = sw_rgb;
            default: pat = '0;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if ((h_reg == 10'd0) || (h_reg == H_ACT - 10'd1) ||
            (v_reg == 10'd0) || (v_reg == V_ACT - 10'd1))
            pat = '1;
`endif
        if (!active)
            pat = '0;
    end

    // Every output is captured on the same tick, so they always describe one pixel.
    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            rgb_reg         <= '0;
            video_on_reg    <= 1'b0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= tick && origin;
            if (tick) begin
                hsync_reg    <= ((h_reg >= HS_FIRST) && (h_reg <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
                vsync_reg    <= ((v_reg >= VS_FIRST) && (v_reg <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
                rgb_reg      <= pat;
                video_on_reg <= active;
                pixel_x_reg  <= h_reg;
                pixel_y_reg  <= v_reg;
            end
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign rgb         = rgb_reg;
    assign video_on    = video_on_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a default-width instance with a short frame for timing,
// bars, checker and reset, and a tiny instance for the bouncing box.
module tb_vga_pattern_gen;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, rst_b;
    logic [2:0] sw_a, sw_b;
    logic [1:0] mode_a, mode_b;
    logic       hs_a, vs_a, von_a, fs_a;
    logic       hs_b, vs_b, von_b, fs_b;
    logic [2:0] rgb_a, rgb_b;
    logic [9:0] px_a, py_a, px_b, py_b;

    int tests = 0;
    int fails = 0;

    int exp_bx [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 11, 10, 9, 8, 7, 6, 5};
    int exp_by [20] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};

    // Line = 800 px * 2 clk = 1600 clocks; frame = 8 lines = 12800 clocks.
    vga_pattern_gen #(
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CHECK_LOG2(2), .BOX_SIZE(4)
    ) dut_a (
        .CLK_50MHZ(clk), .reset(rst_a), .sw(sw_a), .mode(mode_a),
        .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .video_on(von_a),
        .pixel_x(px_a), .pixel_y(py_a), .frame_start(fs_a)
    );

    // 20 x 11 pixels, one clock per pixel: 220 clocks per frame.
    vga_pattern_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .CHECK_LOG2(2), .BOX_SIZE(4)
    ) dut_b (
        .CLK_50MHZ(clk), .reset(rst_b), .sw(sw_b), .mode(mode_b),
        .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .video_on(von_b),
        .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
        $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic wait_pixel_a(input int x, input int y);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < 40000) begin
            @(negedge clk);
            n++;
            if (px_a == 10'(x) && py_a == 10'(y)) found = 1'b1;
        end
        chk($sformatf("reach_%0d_%0d", x, y), 32'(found), 1);
    endtask

    task automatic wait_fs_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_a && n < 40000);
        chk("fs_a_seen", 32'(fs_a), 1);
    endtask

    task automatic pix_a(input string tag, input int x, input int y, input logic [2:0] exp_rgb);
        wait_pixel_a(x, y);
        chk(tag, 32'(rgb_a), 32'(exp_rgb));
    endtask

    initial begin
        int n;
        int hs_low, vs_low, von_cnt, fs_cnt, rgb_bad, sync_bad, fall1, fall2, run1;
        logic prev_hs;
        int minx, miny, lit;

        rst_a = 1'b1; rst_b = 1'b1;
        mode_a = 2'd0; sw_a = 3'b101;
        mode_b = 2'd3; sw_b = 3'b111;
        repeat (4) @(negedge clk);

        chk("rst_hsync", 32'(hs_a), 1);
        chk("rst_vsync", 32'(vs_a), 1);
        chk("rst_rgb", 32'(rgb_a), 0);
        chk("rst_video_on", 32'(von_a), 0);
        chk("rst_pixel_x", 32'(px_a), 0);
        chk("rst_pixel_y", 32'(py_a), 0);
        chk("rst_frame_start", 32'(fs_a), 0);

        rst_a = 1'b0;
        wait_fs_a(n);
        chk("first_fs_latency", 32'(n), 2);
        chk("fs_pixel_x", 32'(px_a), 0);
        chk("fs_pixel_y", 32'(py_a), 0);
        chk("fs_video_on", 32'(von_a), 1);
        chk("fs_rgb_solid", 32'(rgb_a), 32'(3'b101));

        // Full-frame sweep of solid mode
        hs_low = 0; vs_low = 0; von_cnt = 0; fs_cnt = 0; rgb_bad = 0; sync_bad = 0;
        fall1 = -1; fall2 = -1; run1 = -1;
        prev_hs = hs_a;
        for (int i = 0; i < 12800; i++) begin
            if (!hs_a) hs_low++;
            if (!vs_a) vs_low++;
            if (von_a) von_cnt++;
            if (fs_a) fs_cnt++;
            if (von_a ? (rgb_a != 3'b101) : (rgb_a != 3'b000)) rgb_bad++;
            if (!hs_a && (px_a < 10'd656 || px_a > 10'd751)) sync_bad++;
            if (!vs_a && py_a != 10'd6) sync_bad++;
            if (prev_hs && !hs_a) begin
                if (fall1 < 0) fall1 = i;
                else if (fall2 < 0) fall2 = i;
            end
            if (!prev_hs && hs_a && run1 < 0) run1 = i - fall1;
            prev_hs = hs_a;
            @(negedge clk);
        end
        chk("hsync_low_per_frame", 32'(hs_low), 1536);
        chk("hsync_run_len", 32'(run1), 192);
        chk("hsync_period", 32'(fall2 - fall1), 1600);
        chk("vsync_low_per_frame", 32'(vs_low), 1600);
        chk("video_on_clocks", 32'(von_cnt), 6400);
        chk("fs_pulses_per_frame", 32'(fs_cnt), 1);
        chk("solid_rgb_bad", 32'(rgb_bad), 0);
        chk("sync_position_bad", 32'(sync_bad), 0);
        chk("frame_period_fs", 32'(fs_a), 1);

        // Mode change mid-frame takes effect only at the next frame
        wait_pixel_a(100, 2);
        mode_a = 2'd1;
        pix_a("still_solid_300_3", 300, 3, 3'b101);
        wait_fs_a(n);
        chk("bars_0_0", 32'(rgb_a), 32'(3'b000));
        pix_a("bars_79", 79, 0, 3'b000);
        pix_a("bars_80", 80, 0, 3'b001);
        pix_a("bars_559", 559, 0, 3'b110);
        pix_a("bars_560", 560, 0, 3'b111);
        pix_a("bars_639", 639, 0, 3'b111);
        pix_a("bars_640", 640, 0, 3'b000);
        chk("bars_640_video_on", 32'(von_a), 0);
        pix_a("bars_240_1", 240, 1, 3'b011);

        wait_pixel_a(700, 1);
        mode_a = 2'd2;
        sw_a = 3'b010;
        pix_a("still_bars_400_2", 400, 2, 3'b101);

        wait_fs_a(n);
        chk("checker_0_0", 32'(rgb_a), 32'(3'b000));
        pix_a("checker_4_0", 4, 0, 3'b010);
        pix_a("checker_8_0", 8, 0, 3'b000);
        pix_a("checker_0_4", 0, 4, 3'b010);
        pix_a("checker_4_4", 4, 4, 3'b000);
        pix_a("checker_300_4", 300, 4, 3'b000);

        // Reset in the middle of a frame
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_hsync", 32'(hs_a), 1);
        chk("midrst_vsync", 32'(vs_a), 1);
        chk("midrst_rgb", 32'(rgb_a), 0);
        chk("midrst_video_on", 32'(von_a), 0);
        chk("midrst_pixel_x", 32'(px_a), 0);
        chk("midrst_pixel_y", 32'(py_a), 0);
        chk("midrst_frame_start", 32'(fs_a), 0);
        rst_a = 1'b0;
        wait_fs_a(n);
        chk("midrst_first_fs", 32'(n), 2);
        wait_fs_a(n);
        chk("midrst_frame_period", 32'(n), 12800);

        // Bouncing box on the small instance
        rst_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_b && n < 1000);
        chk("box_first_fs", 32'(n), 1);
        for (int f = 0; f < 20; f++) begin
            chk($sformatf("box_fs_f%0d", f), 32'(fs_b), 1);
            minx = 1023; miny = 1023; lit = 0;
            for (int i = 0; i < 220; i++) begin
                if (von_b && rgb_b != 3'b000) begin
                    lit++;
                    if (int'(px_b) < minx) minx = int'(px_b);
                    if (int'(py_b) < miny) miny = int'(py_b);
                end
                @(negedge clk);
            end
            chk($sformatf("box_x_f%0d", f), 32'(minx), 32'(exp_bx[f]));
            chk($sformatf("box_y_f%0d", f), 32'(miny), 32'(exp_by[f]));
            chk($sformatf("box_area_f%0d", f), 32'(lit), 16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
